// File: rtl/bp_me_network_pkt_serializer_req_pkg.sv
// Shared sizing helpers for the LCE->CCE request wormhole packet.
// The serializer uses the same width and flit-count math as the CCE-side
// decoders, so both ends always agree on the packet layout.

`ifndef BP_ME_NETWORK_PKT_MACROS
`define BP_ME_NETWORK_PKT_MACROS
`define BP_ME_PKT_WIDTH(payload_w, len_w, x_w, y_w) ((payload_w) + (len_w) + (x_w) + (y_w))
`define BP_ME_NUM_FLITS(pkt_w, flit_w) (((pkt_w) + (flit_w) - 1) / (flit_w))
`endif

package bp_me_network_pkt_serializer_req_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Total wormhole packet width {payload, length, y, x}.
  function automatic int pkt_width(input int payload_w, input int len_w,
                                   input int x_w, input int y_w);
    return `BP_ME_PKT_WIDTH(payload_w, len_w, x_w, y_w);
  endfunction

  // Number of flits needed to carry a packet.
  function automatic int num_flits(input int pkt_w, input int flit_w);
    return `BP_ME_NUM_FLITS(pkt_w, flit_w);
  endfunction

  // Value stored in the packet length field: flits minus one.
  function automatic int len_field(input int pkt_w, input int flit_w);
    return `BP_ME_NUM_FLITS(pkt_w, flit_w) - 1;
  endfunction

endpackage

// File: rtl/bp_me_network_pkt_serializer_req_if.sv
// Request-side and link-side handshake bundle of the request serializer.
// master: the LCE / link environment; slave: the serializer itself.

interface bp_me_network_pkt_serializer_req_if
  import bp_me_network_pkt_serializer_req_pkg::*;
#(
  parameter int payload_width_p = 100,
  parameter int dst_id_width_p  = 3,
  parameter int flit_width_p    = 32
);

  logic [payload_width_p-1:0] payload_i;
  logic [dst_id_width_p-1:0]  dst_id_i;
  logic                       long_i;
  logic                       v_i;
  logic                       ready_o;
  logic [flit_width_p-1:0]    link_data_o;
  logic                       link_v_o;
  logic                       link_ready_i;

  modport master (
    output payload_i, dst_id_i, long_i, v_i, link_ready_i,
    input  ready_o, link_data_o, link_v_o
  );

  modport slave (
    input  payload_i, dst_id_i, long_i, v_i, link_ready_i,
    output ready_o, link_data_o, link_v_o
  );

endinterface

// File: rtl/bp_me_network_pkt_serializer_req_hdr_gen.sv
// Combinational routing header generator: maps a destination CCE id and the
// message kind onto the {length, y, x} low bits of the wormhole packet.

module bp_me_network_pkt_serializer_req_hdr_gen
  import bp_me_network_pkt_serializer_req_pkg::*;
#(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int len_width_p    = 2,
  parameter int dst_id_width_p = 3,
  parameter int dst_x_stride_p = 2,
  parameter int dst_x_offset_p = 0,
  parameter int dst_y_p        = 0,
  parameter int long_len_p     = 3,
  parameter int short_len_p    = 1
)(
  input  logic [dst_id_width_p-1:0]                             dst_id_i,
  input  logic                                                  long_i,
  output logic [len_width_p-1:0]                                len_o,
  output logic [len_width_p+y_cord_width_p+x_cord_width_p-1:0] hdr_o
);

  logic [x_cord_width_p-1:0] x_cord;
  logic [y_cord_width_p-1:0] y_cord;

  // Linear id-to-column map; all CCEs share one row.
  always_comb begin
    x_cord = x_cord_width_p'(32'(dst_id_i) * 32'(dst_x_stride_p) + 32'(dst_x_offset_p));
    y_cord = y_cord_width_p'(dst_y_p);
    len_o  = long_i ? len_width_p'(long_len_p) : len_width_p'(short_len_p);
    hdr_o  = {len_o, y_cord, x_cord};
  end

endmodule

// File: rtl/bp_me_network_pkt_serializer_req.sv
// LCE-to-CCE request injector: packs one request into a wormhole packet and
// streams it onto the mesh link one flit per handshake, back-to-back capable.

module bp_me_network_pkt_serializer_req
  import bp_me_network_pkt_serializer_req_pkg::*;
#(
  parameter int payload_width_p       = 100,
  parameter int short_payload_width_p = 40,
  parameter int flit_width_p          = 32,
  parameter int max_num_flit_p        = 4,
  parameter int x_cord_width_p        = 4,
  parameter int y_cord_width_p        = 4,
  parameter int dst_id_width_p        = 3,
  parameter int dst_x_stride_p        = 2,
  parameter int dst_x_offset_p        = 0,
  parameter int dst_y_p               = 0
)(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  bp_me_network_pkt_serializer_req_if.slave      bus
);

  localparam int len_width_lp   = safe_clog2(max_num_flit_p);
  localparam int hdr_width_lp   = len_width_lp + y_cord_width_p + x_cord_width_p;
  localparam int long_width_lp  = pkt_width(payload_width_p, len_width_lp,
                                            x_cord_width_p, y_cord_width_p);
  localparam int short_width_lp = pkt_width(short_payload_width_p, len_width_lp,
                                            x_cord_width_p, y_cord_width_p);
  localparam int long_flits_lp  = num_flits(long_width_lp, flit_width_p);
  localparam int short_flits_lp = num_flits(short_width_lp, flit_width_p);
  localparam int buf_width_lp   = max_num_flit_p * flit_width_p;

  localparam logic [payload_width_p-1:0] short_mask_lp =
    {payload_width_p{1'b1}} >> (payload_width_p - short_payload_width_p);

  if (flit_width_p < hdr_width_lp) begin : g_chk_hdr
    $error("flit_width_p cannot hold the {length, y, x} header");
  end
  if (long_flits_lp > max_num_flit_p) begin : g_chk_flits
    $error("long packet needs more than max_num_flit_p flits");
  end
  if (short_payload_width_p > payload_width_p) begin : g_chk_short
    $error("short_payload_width_p exceeds payload_width_p");
  end

  logic [len_width_lp-1:0]    len;
  logic [hdr_width_lp-1:0]    hdr;
  logic [payload_width_p-1:0] payload_masked;
  logic [buf_width_lp-1:0]    pkt_next;

  logic [buf_width_lp-1:0]    pkt_p1;
  logic [len_width_lp-1:0]    cnt_p1;
  state_e                     state, state_n;

  logic ready;
  logic link_v;
  logic load;
  logic shift;

  bp_me_network_pkt_serializer_req_hdr_gen #(
    .x_cord_width_p (x_cord_width_p),
    .y_cord_width_p (y_cord_width_p),
    .len_width_p    (len_width_lp),
    .dst_id_width_p (dst_id_width_p),
    .dst_x_stride_p (dst_x_stride_p),
    .dst_x_offset_p (dst_x_offset_p),
    .dst_y_p        (dst_y_p),
    .long_len_p     (long_flits_lp - 1),
    .short_len_p    (short_flits_lp - 1)
  ) hdr_gen (
    .dst_id_i (bus.dst_id_i),
    .long_i   (bus.long_i),
    .len_o    (len),
    .hdr_o    (hdr)
  );

  // Assemble the zero-padded packet; short requests drop the upper payload bits.
  always_comb begin
    payload_masked = bus.long_i ? bus.payload_i : (bus.payload_i & short_mask_lp);
    pkt_next       = buf_width_lp'({payload_masked, hdr});
  end

  // Next-state and handshake decode; ready only looks at link_ready_i in SEND.
  always_comb begin
    state_n = state;
    ready   = 1'b0;
    link_v  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    if (!reset_i) begin
      case (state)
        IDLE: begin
          ready = 1'b1;
          if (bus.v_i) begin
            load    = 1'b1;
            state_n = SEND;
          end
        end
        SEND: begin
          link_v = 1'b1;
          if (bus.link_ready_i) begin
            shift = 1'b1;
            if (cnt_p1 == '0) begin
              ready = 1'b1;
              if (bus.v_i) begin
                load = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, flit counter and packet shift register; a new load overrides the shift.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      cnt_p1 <= '0;
      pkt_p1 <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        pkt_p1 <= pkt_next;
        cnt_p1 <= len;
      end else if (shift) begin
        pkt_p1 <= pkt_p1 >> flit_width_p;
        if (cnt_p1 != '0) begin
          cnt_p1 <= cnt_p1 - 1'b1;
        end
      end
    end
  end

  assign bus.ready_o     = ready;
  assign bus.link_v_o    = link_v;
  assign bus.link_data_o = reset_i ? '0 : pkt_p1[flit_width_p-1:0];

endmodule

// File: tb/tb_bp_me_network_pkt_serializer_req.sv
// Scoreboard bench for the request serializer: the driver pushes the expected
// flit stream of each accepted request, the monitor checks every link cycle.

module tb_bp_me_network_pkt_serializer_req;
  import bp_me_network_pkt_serializer_req_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bp_me_network_pkt_serializer_req_if #(
    .payload_width_p (100),
    .dst_id_width_p  (3),
    .flit_width_p    (32)
  ) bus ();

  bp_me_network_pkt_serializer_req #(
    .payload_width_p       (100),
    .short_payload_width_p (40),
    .flit_width_p          (32),
    .max_num_flit_p        (4),
    .x_cord_width_p        (4),
    .y_cord_width_p        (4),
    .dst_id_width_p        (3),
    .dst_x_stride_p        (2),
    .dst_x_offset_p        (0),
    .dst_y_p               (0)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   run_len = 0;
  int   max_run = 0;

  localparam logic [99:0] P_RST   = 100'h3_0000_0000_0000_0055_AA55_AA55;
  localparam logic [99:0] P_LONG  = 100'h1_2345_6789_ABCD_EF01_2345_6789;
  localparam logic [99:0] P_SHORT = 100'hF_FFFF_FFFF_FFFF_FF12_3456_789A;
  localparam logic [99:0] P_BP    = 100'h8_0F0F_0F0F_A5A5_A5A5_C3C3_C3C3;
  localparam logic [99:0] P_S1    = 100'hA_AAAA_AAAA_AAAA_AA00_1122_3344;
  localparam logic [99:0] P_L2    = 100'h5_5555_5555_DEAD_BEEF_CAFE_F00D;
  localparam logic [99:0] P_S3    = 100'h0_0000_0000_0000_00FE_DCBA_9876;
  localparam logic [99:0] P_S4    = 100'hF_0000_0000_0000_0077_6655_4433;

  // Expected flits: {zero pad, payload (40-bit masked when short), hand-computed header}.
  task automatic push_pkt(input logic [99:0] pl, input logic lg, input logic [9:0] hdr);
    logic [99:0]  p;
    logic [127:0] pkt;
    exp_t         e;
    int           n;
    p   = lg ? pl : (pl & {60'd0, {40{1'b1}}});
    pkt = {18'd0, p, hdr};
    n   = lg ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      e.data = pkt[i*32 +: 32];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Present a request and hold it until it is accepted (bounded).
  task automatic send(input logic [99:0] pl, input logic [2:0] dst, input logic lg,
                      input logic [9:0] hdr);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.payload_i = pl;
    bus.dst_id_i  = dst;
    bus.long_i    = lg;
    bus.v_i       = 1'b1;
    #3;
    while (!bus.ready_o && waited < 50) begin
      @(negedge clk);
      #3;
      waited++;
    end
    if (!bus.ready_o) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: ready_o=0 required 1");
    end else begin
      push_pkt(pl, lg, hdr);
    end
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s_drain: %0d flits outstanding, required 0", name, exp_q.size());
    end
  endtask

  // Monitor: sample just before each rising edge and compare against the scoreboard.
  initial begin
    exp_t head;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        run_len = 0;
        n_vec++;
        if (bus.ready_o !== 1'b0 || bus.link_v_o !== 1'b0 || bus.link_data_o !== 32'd0) begin
          n_miss++;
          $display("FAIL reset_outputs: ready=%b v=%b data=%h required 0 0 00000000",
                   bus.ready_o, bus.link_v_o, bus.link_data_o);
        end
      end else if (bus.link_v_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          run_len = 0;
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_flit: data=%h required no flit", bus.link_data_o);
        end else begin
          head = exp_q[0];
          n_vec++;
          if (bus.link_ready_i) begin
            if (bus.link_data_o !== head.data || bus.ready_o !== head.last) begin
              n_miss++;
              $display("FAIL flit: data=%h ready=%b required data=%h ready=%b",
                       bus.link_data_o, bus.ready_o, head.data, head.last);
            end
            void'(exp_q.pop_front());
            run_len++;
            if (run_len > max_run) max_run = run_len;
          end else begin
            run_len = 0;
            if (bus.link_data_o !== head.data || bus.ready_o !== 1'b0) begin
              n_miss++;
              $display("FAIL stall: data=%h ready=%b required data=%h ready=0",
                       bus.link_data_o, bus.ready_o, head.data);
            end
          end
        end
      end else begin
        run_len = 0;
        n_vec++;
        if (bus.ready_o !== 1'b1) begin
          n_miss++;
          $display("FAIL idle_ready: ready=%b required 1", bus.ready_o);
        end
      end
    end
  end

  initial begin
    bus.payload_i    = P_RST;
    bus.dst_id_i     = 3'd0;
    bus.long_i       = 1'b0;
    bus.v_i          = 1'b1;
    bus.link_ready_i = 1'b1;

    // Reset with a request held pending; it is taken on the first cycle out of reset.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    n_vec++;
    if (bus.ready_o !== 1'b1) begin
      n_miss++;
      $display("FAIL post_reset_ready: ready=%b required 1", bus.ready_o);
    end else begin
      push_pkt(P_RST, 1'b0, 10'h100);
    end
    @(negedge clk);
    bus.v_i = 1'b0;
    drain("reset_pkt");

    // Long request to CCE 3.
    send(P_LONG, 3'd3, 1'b1, 10'h306);
    @(negedge clk);
    bus.v_i = 1'b0;
    drain("long");

    // Short request to CCE 5 with garbage above the short payload.
    send(P_SHORT, 3'd5, 1'b0, 10'h10A);
    @(negedge clk);
    bus.v_i = 1'b0;
    drain("short");

    // Link back-pressure during a long packet.
    send(P_BP, 3'd3, 1'b1, 10'h306);
    begin
      logic [5:0] pat;
      pat = 6'b111001;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        bus.v_i          = 1'b0;
        bus.link_ready_i = pat[i];
      end
    end
    @(negedge clk);
    bus.link_ready_i = 1'b1;
    drain("backpressure");

    // Back-to-back short, long, short: eight uninterrupted flit cycles.
    max_run = 0;
    send(P_S1, 3'd1, 1'b0, 10'h102);
    send(P_L2, 3'd2, 1'b1, 10'h304);
    send(P_S3, 3'd7, 1'b0, 10'h10E);
    @(negedge clk);
    bus.v_i = 1'b0;
    drain("b2b");
    n_vec++;
    if (max_run != 8) begin
      n_miss++;
      $display("FAIL b2b_run: %0d consecutive flits, required 8", max_run);
    end

    // Reset after two flits of a long packet abandons the rest.
    send(P_LONG, 3'd3, 1'b1, 10'h306);
    @(negedge clk);
    bus.v_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    send(P_S4, 3'd5, 1'b0, 10'h10A);
    @(negedge clk);
    bus.v_i = 1'b0;
    drain("after_reset");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
